// File: rtl/md4_msg_padder_pkg.sv
// md4_msg_padder_pkg: shared types and constants for the MD4 message padder.
// State enum, block geometry and the byte-to-bit-lane mapping of the 512-bit block.
package md4_msg_padder_pkg;

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_PAD  = 2'd1,
        ST_LEN  = 2'd2,
        ST_EMIT = 2'd3
    } md4_state_e;

    localparam int         MD4_BLK_BYTES = 64;
    localparam int         MD4_LEN_OFS   = 56;
    localparam logic [7:0] MD4_PAD_BYTE  = 8'h80;

    // Bit offset of message byte n inside blk_data: word n/4 sits at
    // [511-32w -: 32] and the byte occupies bits [8*(n%4) +: 8] of that word.
    function automatic int byte_lane(input int n);
        return 480 - 32 * (n / 4) + 8 * (n % 4);
    endfunction

endpackage

// File: rtl/md4_msg_padder_if.sv
// md4_msg_padder_if: byte input stream and block output stream of the padder.
// Handshake rule for both streams: a transfer happens on a rising clk edge
// where valid && ready; the source holds data/last stable while valid && !ready.
interface md4_msg_padder_if;

    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_data;
    logic         in_last;

    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_data;
    logic         blk_last;

    // Host / downstream side: drives bytes in, accepts blocks out.
    modport master (
        output in_valid, in_data, in_last, blk_ready,
        input  in_ready, blk_valid, blk_data, blk_last
    );

    // Padder side.
    modport slave (
        input  in_valid, in_data, in_last, blk_ready,
        output in_ready, blk_valid, blk_data, blk_last
    );

endinterface

// File: rtl/md4_msg_padder_pad_buffer.sv
// md4_msg_padder_pad_buffer: 64 x 8 block register file.
// Supports a single byte write, 0x80 + zero fill from an index upward,
// a 64-bit little-endian length write into bytes 56..63, clear-all,
// and a packed 512-bit read in the core's word order.
module md4_msg_padder_pad_buffer
    import md4_msg_padder_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         wr_en,
    input  logic [5:0]   wr_idx,
    input  logic [7:0]   wr_data,
    input  logic         pad_en,
    input  logic [5:0]   pad_idx,
    input  logic         len_en,
    input  logic [63:0]  len_val,
    input  logic         clr,
    output logic [511:0] data
);

    logic [7:0] mem [MD4_BLK_BYTES];

    // Byte storage; later statements win, so the length field overrides
    // both the pad fill and the clear in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < MD4_BLK_BYTES; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < MD4_BLK_BYTES; i++) begin
                if (wr_en && (wr_idx == 6'(i))) begin
                    mem[i] <= wr_data;
                end
                if (clr) begin
                    mem[i] <= '0;
                end
                if (pad_en && (6'(i) >= pad_idx)) begin
                    mem[i] <= (6'(i) == pad_idx) ? MD4_PAD_BYTE : 8'h00;
                end
            end
            for (int k = 0; k < 8; k++) begin
                if (len_en) begin
                    mem[MD4_LEN_OFS + k] <= len_val[8*k +: 8];
                end
            end
        end
    end

    // Packed read in the message-word layout the core consumes.
    always_comb begin
        data = '0;
        for (int n = 0; n < MD4_BLK_BYTES; n++) begin
            data[byte_lane(n) +: 8] = mem[n];
        end
    end

endmodule

// File: rtl/md4_msg_padder.sv
// md4_msg_padder: byte-stream front end for the MD4 core.
// Collects message bytes, applies MD4 padding (0x80, zeros, 64-bit LE bit
// length) and emits 512-bit blocks with a last flag on the length block.
// Optional feature macro: MD4_PAD_ZERO_LEN_EN adds a msg_empty input that
// requests the padding block of a zero-length message.
module md4_msg_padder
    import md4_msg_padder_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    md4_msg_padder_if.slave    bus,
    output logic               busy,
    output md4_state_e         dbg_state
`ifdef MD4_PAD_ZERO_LEN_EN
    ,
    input  logic               msg_empty
`endif
);

    md4_state_e         state, state_d;
    logic [5:0]         ptr, ptr_d;
    logic [CNT_W-1:0]   count, count_d;
    logic               last_q, last_d;
    logic               pad_pend, pad_pend_d;
    logic               len_pend, len_pend_d;

    logic               buf_wr, buf_pad, buf_len, buf_clr;
    logic [63:0]        len_bits;
    logic [511:0]       buf_data;

    // Bit length of the message; byte count wraps mod 2^CNT_W.
    assign len_bits = 64'(count) << 3;

    md4_msg_padder_pad_buffer u_buf (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (buf_wr),
        .wr_idx  (ptr),
        .wr_data (bus.in_data),
        .pad_en  (buf_pad),
        .pad_idx (ptr),
        .len_en  (buf_len),
        .len_val (len_bits),
        .clr     (buf_clr),
        .data    (buf_data)
    );

    assign bus.in_ready  = (state == ST_FILL);
    assign bus.blk_valid = (state == ST_EMIT);
    assign bus.blk_last  = (state == ST_EMIT) && last_q;
    assign bus.blk_data  = buf_data;
    assign busy          = (state != ST_FILL) || (ptr != '0);
    assign dbg_state     = state;

    // State and counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_FILL;
            ptr      <= '0;
            count    <= '0;
            last_q   <= 1'b0;
            pad_pend <= 1'b0;
            len_pend <= 1'b0;
        end else begin
            state    <= state_d;
            ptr      <= ptr_d;
            count    <= count_d;
            last_q   <= last_d;
            pad_pend <= pad_pend_d;
            len_pend <= len_pend_d;
        end
    end

    // Next-state logic and buffer control.
    always_comb begin
        state_d    = state;
        ptr_d      = ptr;
        count_d    = count;
        last_d     = last_q;
        pad_pend_d = pad_pend;
        len_pend_d = len_pend;
        buf_wr     = 1'b0;
        buf_pad    = 1'b0;
        buf_len    = 1'b0;
        buf_clr    = 1'b0;

        case (state)
            ST_FILL: begin
                if (bus.in_valid) begin
                    buf_wr  = 1'b1;
                    ptr_d   = ptr + 6'd1;
                    count_d = count + CNT_W'(1);
                    if (ptr == 6'd63) begin
                        // Full data block; padding (if this was the last
                        // byte) goes into a fresh block after it leaves.
                        state_d    = ST_EMIT;
                        last_d     = 1'b0;
                        pad_pend_d = bus.in_last;
                    end else if (bus.in_last) begin
                        state_d = ST_PAD;
                    end
                end
`ifdef MD4_PAD_ZERO_LEN_EN
                // A real byte takes precedence over an empty-message request.
                else if (msg_empty && (ptr == '0) && (count == '0)) begin
                    state_d = ST_PAD;
                end
`endif
            end

            ST_PAD: begin
                buf_pad = 1'b1;
                state_d = ST_EMIT;
                if (ptr <= 6'(MD4_LEN_OFS - 1)) begin
                    buf_len = 1'b1;
                    last_d  = 1'b1;
                end else begin
                    // No room for the length field: it gets its own block.
                    last_d     = 1'b0;
                    len_pend_d = 1'b1;
                end
            end

            ST_LEN: begin
                buf_clr    = 1'b1;
                buf_len    = 1'b1;
                state_d    = ST_EMIT;
                last_d     = 1'b1;
                len_pend_d = 1'b0;
            end

            ST_EMIT: begin
                if (bus.blk_ready) begin
                    if (last_q) begin
                        state_d    = ST_FILL;
                        ptr_d      = '0;
                        count_d    = '0;
                        last_d     = 1'b0;
                        pad_pend_d = 1'b0;
                        len_pend_d = 1'b0;
                    end else if (len_pend) begin
                        state_d = ST_LEN;
                    end else if (pad_pend) begin
                        state_d    = ST_PAD;
                        ptr_d      = '0;
                        pad_pend_d = 1'b0;
                    end else begin
                        state_d = ST_FILL;
                    end
                end
            end

            default: begin
                state_d = ST_FILL;
            end
        endcase
    end

endmodule
